cam_search_pipe: RTL

- Parametrised content-addressable memory; next generation of the 16x16 CAM, generalised in width and depth.
- Adds per-entry valid bits, explicit invalidate and an occupancy counter.
- Search is a 2-stage pipelined request/response path with hit, multi-hit and priority-encoded address.
- Sits between the lookup requester (key in) and the table-management logic (write/invalidate in, occupancy out).

---
 rtl/cam_search_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cam_search_pipe.sv
// ============================================================================
// Module   : cam_search_pipe
// Purpose  : Parametrised CAM with per-entry valid bits, an occupancy counter
//            and a 2-stage pipelined search. Define CAM_TERNARY_EN to build
//            per-entry don't-care masks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_search_pipe #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] wr_mask_i,
    input  logic              srch_valid_i,
    input  logic [DATA_W-1:0] srch_key_i,
    output logic              rsp_valid_o,
    output logic              rsp_hit_o,
    output logic              rsp_multi_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic [DEPTH-1:0]  rsp_onehot_o,
    output logic [ADDR_W:0]   occ_count_o,
    output logic              full_o
);

    localparam logic [ADDR_W:0] c_full_count = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W:0]   occ_q;
    logic [ADDR_W:0]   occ_d;
    logic [DEPTH-1:0]  match_w;

    logic              s1_valid_q;
    logic [DEPTH-1:0]  s1_match_q;

    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic              rsp_multi_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DEPTH-1:0]  rsp_onehot_q;
    logic              rsp_hit_d;
    logic              rsp_multi_d;
    logic [ADDR_W-1:0] rsp_addr_d;

    // ------------------------------------------------------------------------
    // Table storage: invalidate clears only the valid bit, data is retained
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_addr_i] <= wr_valid_i;
            if (wr_valid_i) begin
                data_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

`ifdef CAM_TERNARY_EN
    logic [DATA_W-1:0] mask_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
            end
        end else if (wr_en_i && wr_valid_i) begin
            mask_q[wr_addr_i] <= wr_mask_i;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match_w[gi] = valid_q[gi] &
                             ~|((data_q[gi] ^ srch_key_i) & ~mask_q[gi]);
    end
`else
    logic unused_mask;
    assign unused_mask = ^wr_mask_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match_w[gi] = valid_q[gi] & (data_q[gi] == srch_key_i);
    end
`endif

    // ------------------------------------------------------------------------
    // Occupancy: only valid-bit transitions move the count, so it cannot wrap
    // ------------------------------------------------------------------------
    always_comb begin
        occ_d = occ_q;
        if (wr_en_i) begin
            if (wr_valid_i && !valid_q[wr_addr_i]) begin
                occ_d = occ_q + 1'b1;
            end else if (!wr_valid_i && valid_q[wr_addr_i]) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: match vector sampled against pre-update table contents
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_match_q <= '0;
        end else begin
            s1_valid_q <= srch_valid_i;
            if (srch_valid_i) begin
                s1_match_q <= match_w;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: priority encode (lowest index wins), multi-hit, hit
    // ------------------------------------------------------------------------
    always_comb begin
        rsp_addr_d = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_match_q[i]) begin
                rsp_addr_d = ADDR_W'(i);
            end
        end
        rsp_hit_d   = |s1_match_q;
        // Clearing the lowest set bit leaves something only if >= 2 bits set
        rsp_multi_d = |(s1_match_q & (s1_match_q - DEPTH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_multi_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_onehot_q <= '0;
        end else begin
            rsp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rsp_hit_q    <= rsp_hit_d;
                rsp_multi_q  <= rsp_multi_d;
                rsp_addr_q   <= rsp_addr_d;
                rsp_onehot_q <= s1_match_q;
            end
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_hit_o    = rsp_hit_q;
    assign rsp_multi_o  = rsp_multi_q;
    assign rsp_addr_o   = rsp_addr_q;
    assign rsp_onehot_o = rsp_onehot_q;
    assign occ_count_o  = occ_q;
    assign full_o       = (occ_q == c_full_count);

endmodule

`default_nettype wire
